// File: rtl/sram_16kb_arbiter_pkg.sv
// Shared constants and types for the 16kb SRAM arbiter.
// Default macro geometry (512 x 32), trim width, the macro request
// record and the optional init FSM state encoding.
package sram_arb_pkg;

   localparam int unsigned DEF_WORDS     = 512;
   localparam int unsigned DEF_DW        = 32;
   localparam int unsigned DEF_CTRL_BITS = 2;
   localparam int unsigned DEF_AW        = $clog2(DEF_WORDS);

   // One macro access as driven on the macro pins (default geometry).
   typedef struct packed {
      logic                csn;
      logic                wen;
      logic [DEF_AW-1:0]   addr;
      logic [DEF_DW-1:0]   din;
      logic [DEF_DW-1:0]   mask;
   } mem_req_t;

   typedef enum logic {
      INIT,
      RUN
   } arb_state_e;

endpackage

// File: rtl/sram_16kb_arbiter_if.sv
// Requester-side bus of the SRAM arbiter.
//   req/we/addr/wdata/wmask : per-requester request fields (flattened, requester i at slice i)
//   gnt                     : one-hot accept
//   r_valid/r_rdata         : one-hot read strobe and shared read data
// master = requester side, slave = arbiter side.
interface sram_16kb_arbiter_if #(
   parameter int unsigned NREQ = 2,
   parameter int unsigned AW   = 9,
   parameter int unsigned DW   = 32
);
   logic [NREQ-1:0]    req;
   logic [NREQ-1:0]    we;
   logic [NREQ*AW-1:0] addr;
   logic [NREQ*DW-1:0] wdata;
   logic [NREQ*DW-1:0] wmask;
   logic [NREQ-1:0]    gnt;
   logic [NREQ-1:0]    r_valid;
   logic [DW-1:0]      r_rdata;

   modport master (
      output req, we, addr, wdata, wmask,
      input  gnt, r_valid, r_rdata
   );

   modport slave (
      input  req, we, addr, wdata, wmask,
      output gnt, r_valid, r_rdata
   );
endinterface

// File: rtl/sram_16kb_arbiter_rr.sv
// Combinational round-robin arbiter.
//   en   : arbitration enable; gnt is all-zero when low
//   req  : request vector
//   ptr  : highest-priority index (register lives in the parent)
//   gnt  : one-hot grant to the first requester at or above ptr, modulo NREQ
module rr_arbiter
   import sram_arb_pkg::*;
#(
   parameter int unsigned NREQ = 2,
   parameter int unsigned PW   = 1
) (
   input  logic            en,
   input  logic [NREQ-1:0] req,
   input  logic [PW-1:0]   ptr,
   output logic [NREQ-1:0] gnt
);

   int unsigned idx;
   logic        found;

   always_comb begin
      gnt   = '0;
      found = 1'b0;
      idx   = 0;
      for (int unsigned off = 0; off < NREQ; off++) begin
         idx = (32'(ptr) + off) % NREQ;
         // Constant-index compare keeps the selects width-clean.
         for (int unsigned i = 0; i < NREQ; i++) begin
            if (i == idx && en && !found && req[i]) begin
               gnt[i] = 1'b1;
               found  = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/sram_16kb_arbiter.sv
// Round-robin arbiter sharing one 512x32 SRAM macro between NREQ requesters.
//   CK, RSTN              : clock, asynchronous active-low reset
//   bus (slave)           : requester req/gnt bus, read return (latency 2)
//   cfg_rddelay/wrdelay   : timing trims, copied to the macro only while idle
//   init_done             : high once traffic is accepted
//   mem_*                 : registered macro pins, mem_dout is macro read data
// Optional feature macro SRAM_ARB_INIT_EN: zero-fill the macro after reset
// (INIT -> RUN) before accepting traffic.
module sram_16kb_arbiter
   import sram_arb_pkg::*;
#(
   parameter int unsigned NREQ      = 2,
   parameter int unsigned WORDS     = DEF_WORDS,
   parameter int unsigned DW        = DEF_DW,
   parameter int unsigned AW        = $clog2(WORDS),
   parameter int unsigned CTRL_BITS = DEF_CTRL_BITS
) (
   input  logic                 CK,
   input  logic                 RSTN,
   sram_16kb_arbiter_if.slave   bus,
   input  logic [CTRL_BITS-1:0] cfg_rddelay,
   input  logic [CTRL_BITS-1:0] cfg_wrdelay,
   output logic                 init_done,
   output logic                 mem_csn,
   output logic                 mem_wen,
   output logic [AW-1:0]        mem_addr,
   output logic [DW-1:0]        mem_din,
   output logic [DW-1:0]        mem_mask,
   output logic [CTRL_BITS-1:0] mem_rddelay,
   output logic [CTRL_BITS-1:0] mem_wrdelay,
   input  logic [DW-1:0]        mem_dout
);

   localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [PW-1:0]        ptr_q, ptr_d;
   logic                 csn_q, csn_d;
   logic                 wen_q, wen_d;
   logic [AW-1:0]        addr_q, addr_d;
   logic [DW-1:0]        din_q, din_d;
   logic [DW-1:0]        mask_q, mask_d;
   logic [CTRL_BITS-1:0] rddly_q, rddly_d;
   logic [CTRL_BITS-1:0] wrdly_q, wrdly_d;
   logic [1:0]           pv_q, pv_d;
   logic [1:0][PW-1:0]   pid_q, pid_d;
   logic                 init_done_q, init_done_d;
   logic                 init_act;
   logic [AW-1:0]        init_addr;
   logic [NREQ-1:0]      gnt;

   rr_arbiter #(
      .NREQ (NREQ),
      .PW   (PW)
   ) u_rr (
      .en  (init_done_q),
      .req (bus.req),
      .ptr (ptr_q),
      .gnt (gnt)
   );

`ifdef SRAM_ARB_INIT_EN
   arb_state_e    state_q, state_d;
   logic [AW-1:0] init_cnt_q, init_cnt_d;

   always_comb begin
      state_d     = state_q;
      init_cnt_d  = init_cnt_q;
      init_done_d = init_done_q;
      init_act    = (state_q == INIT);
      init_addr   = init_cnt_q;
      if (state_q == INIT) begin
         init_cnt_d = init_cnt_q + 1'b1;
         if (init_cnt_q == AW'(WORDS - 1)) begin
            state_d     = RUN;
            init_done_d = 1'b1;
         end
      end
   end
`else
   always_comb begin
      init_act    = 1'b0;
      init_addr   = '0;
      init_done_d = 1'b1;
   end
`endif

   always_comb begin
      ptr_d    = ptr_q;
      csn_d    = 1'b1;
      wen_d    = 1'b1;
      addr_d   = addr_q;
      din_d    = din_q;
      mask_d   = mask_q;
      pv_d     = {pv_q[0], 1'b0};
      pid_d    = {pid_q[0], PW'(0)};
      if (init_act) begin
         csn_d  = 1'b0;
         wen_d  = 1'b0;
         addr_d = init_addr;
         din_d  = '0;
         mask_d = '1;
      end else begin
         for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
               csn_d    = 1'b0;
               wen_d    = ~bus.we[i];
               addr_d   = bus.addr[i*AW +: AW];
               din_d    = bus.wdata[i*DW +: DW];
               mask_d   = bus.wmask[i*DW +: DW];
               ptr_d    = (i == NREQ - 1) ? '0 : PW'(i + 1);
               pv_d[0]  = ~bus.we[i];
               pid_d[0] = PW'(i);
            end
         end
      end
      // Trims only move when the next macro cycle is idle.
      rddly_d = csn_d ? cfg_rddelay : rddly_q;
      wrdly_d = csn_d ? cfg_wrdelay : wrdly_q;
   end

   always_ff @(posedge CK or negedge RSTN) begin
      if (!RSTN) begin
         ptr_q       <= '0;
         csn_q       <= 1'b1;
         wen_q       <= 1'b1;
         addr_q      <= '0;
         din_q       <= '0;
         mask_q      <= '0;
         rddly_q     <= '0;
         wrdly_q     <= '0;
         pv_q        <= '0;
         pid_q       <= '0;
         init_done_q <= 1'b0;
`ifdef SRAM_ARB_INIT_EN
         state_q     <= INIT;
         init_cnt_q  <= '0;
`endif
      end else begin
         ptr_q       <= ptr_d;
         csn_q       <= csn_d;
         wen_q       <= wen_d;
         addr_q      <= addr_d;
         din_q       <= din_d;
         mask_q      <= mask_d;
         rddly_q     <= rddly_d;
         wrdly_q     <= wrdly_d;
         pv_q        <= pv_d;
         pid_q       <= pid_d;
         init_done_q <= init_done_d;
`ifdef SRAM_ARB_INIT_EN
         state_q     <= state_d;
         init_cnt_q  <= init_cnt_d;
`endif
      end
   end

   always_comb begin
      for (int unsigned i = 0; i < NREQ; i++) begin
         bus.r_valid[i] = pv_q[1] && (pid_q[1] == PW'(i));
      end
   end

   assign bus.gnt     = gnt;
   assign bus.r_rdata = mem_dout;
   assign init_done   = init_done_q;
   assign mem_csn     = csn_q;
   assign mem_wen     = wen_q;
   assign mem_addr    = addr_q;
   assign mem_din     = din_q;
   assign mem_mask    = mask_q;
   assign mem_rddelay = rddly_q;
   assign mem_wrdelay = wrdly_q;

endmodule

// File: tb/tb_sram_16kb_arbiter.sv
// Directed bench for sram_16kb_arbiter with a behavioural 512x32 macro.
module tb_sram_16kb_arbiter;

   localparam int unsigned NREQ = 2;
   localparam int unsigned AW   = 9;
   localparam int unsigned DW   = 32;
   localparam int unsigned CB   = 2;
`ifdef SRAM_ARB_INIT_EN
   localparam int INIT_CYC = 512;
`else
   localparam int INIT_CYC = 1;
`endif

   logic          CK = 1'b0;
   logic          RSTN;
   logic [CB-1:0] cfg_rddelay, cfg_wrdelay;
   logic          init_done;
   logic          mem_csn, mem_wen;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_din, mem_mask, mem_dout;
   logic [CB-1:0] mem_rddelay, mem_wrdelay;
   logic [DW-1:0] sram [0:511];

   int n_tests = 0;
   int n_fail  = 0;

   sram_16kb_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

   sram_16kb_arbiter #(
      .NREQ(NREQ), .WORDS(512), .DW(DW), .AW(AW), .CTRL_BITS(CB)
   ) dut (
      .CK          (CK),
      .RSTN        (RSTN),
      .bus         (bus),
      .cfg_rddelay (cfg_rddelay),
      .cfg_wrdelay (cfg_wrdelay),
      .init_done   (init_done),
      .mem_csn     (mem_csn),
      .mem_wen     (mem_wen),
      .mem_addr    (mem_addr),
      .mem_din     (mem_din),
      .mem_mask    (mem_mask),
      .mem_rddelay (mem_rddelay),
      .mem_wrdelay (mem_wrdelay),
      .mem_dout    (mem_dout)
   );

   always #5 CK = ~CK;

   // Synchronous macro: read data appears the cycle after the access.
   always @(posedge CK) begin
      if (!mem_csn) begin
         if (!mem_wen) sram[mem_addr] <= (sram[mem_addr] & ~mem_mask) | (mem_din & mem_mask);
         else          mem_dout <= sram[mem_addr];
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic set_req(input int i, input logic r, input logic w, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [DW-1:0] m);
      bus.req[i]             = r;
      bus.we[i]              = w;
      bus.addr[i*AW +: AW]   = a;
      bus.wdata[i*DW +: DW]  = d;
      bus.wmask[i*DW +: DW]  = m;
   endtask

   // Caller holds req high; gnt must stay quiet until init_done rises.
   task automatic wait_ready(input string tag, input int exp_cyc);
      int   n    = 0;
      logic gbad = 1'b0;
      while (init_done !== 1'b1 && n < 2000) begin
         @(negedge CK);
         n++;
         if (init_done !== 1'b1 && bus.gnt !== '0) gbad = 1'b1;
      end
      bus.req = '0;
      check_eq({tag, "_init_cycles"}, n, exp_cyc);
      check_eq({tag, "_gnt_quiet"}, {31'd0, gbad}, 32'd0);
   endtask

   task automatic wr0(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [DW-1:0] m);
      @(negedge CK);
      set_req(0, 1'b1, 1'b1, a, d, m);
      #1 check_eq({tag, "_gnt"}, {30'd0, bus.gnt}, 32'h1);
      @(negedge CK);
      bus.req = '0;
      #1;
      check_eq({tag, "_csn"}, {31'd0, mem_csn}, 32'd0);
      check_eq({tag, "_wen"}, {31'd0, mem_wen}, 32'd0);
      check_eq({tag, "_addr"}, {23'd0, mem_addr}, {23'd0, a});
      check_eq({tag, "_din"}, mem_din, d);
      check_eq({tag, "_mask"}, mem_mask, m);
   endtask

   task automatic rd0(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp);
      @(negedge CK);
      set_req(0, 1'b1, 1'b0, a, '0, '0);
      #1 check_eq({tag, "_gnt"}, {30'd0, bus.gnt}, 32'h1);
      @(negedge CK);
      bus.req = '0;
      #1 check_eq({tag, "_rv_t1"}, {30'd0, bus.r_valid}, 32'h0);
      @(negedge CK);
      #1;
      check_eq({tag, "_rv_t2"}, {30'd0, bus.r_valid}, 32'h1);
      check_eq({tag, "_rdata"}, bus.r_rdata, exp);
   endtask

   logic [1:0]  exp_gnt [8] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b00, 2'b00};
   logic [1:0]  exp_rv  [8] = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};

   initial begin
      RSTN        = 1'b0;
      cfg_rddelay = '0;
      cfg_wrdelay = '0;
      bus.req     = '1;
      bus.we      = '0;
      bus.addr    = '0;
      bus.wdata   = '0;
      bus.wmask   = '0;

      // T1 reset
      repeat (2) @(negedge CK);
      #1;
      check_eq("t1_gnt", {30'd0, bus.gnt}, 32'h0);
      check_eq("t1_csn", {31'd0, mem_csn}, 32'h1);
      check_eq("t1_wen", {31'd0, mem_wen}, 32'h1);
      check_eq("t1_rv", {30'd0, bus.r_valid}, 32'h0);
      check_eq("t1_init_done", {31'd0, init_done}, 32'h0);
      check_eq("t1_addr", {23'd0, mem_addr}, 32'h0);
      @(negedge CK);
      RSTN = 1'b1;
      wait_ready("t1", INIT_CYC);

`ifdef SRAM_ARB_INIT_EN
      // T6 init: top word zero-filled, restart from 0 on reset
      rd0("t6_rd1ff", 9'h1FF, 32'h0);
      @(negedge CK);
      RSTN    = 1'b0;
      bus.req = '1;
      @(negedge CK);
      RSTN = 1'b1;
      repeat (101) @(negedge CK);
      #1 check_eq("t6_addr100", {23'd0, mem_addr}, 32'd100);
      RSTN = 1'b0;
      #1 check_eq("t6_rst_addr", {23'd0, mem_addr}, 32'd0);
      @(negedge CK);
      RSTN = 1'b1;
      @(negedge CK);
      #1;
      check_eq("t6_restart_addr", {23'd0, mem_addr}, 32'd0);
      check_eq("t6_restart_csn", {31'd0, mem_csn}, 32'd0);
      check_eq("t6_restart_wen", {31'd0, mem_wen}, 32'd0);
      wait_ready("t6", INIT_CYC - 1);
`endif

      // T2 write/read
      wr0("t2w", 9'h005, 32'hDEADBEEF, 32'hFFFFFFFF);
      rd0("t2r", 9'h005, 32'hDEADBEEF);

      // T3 masked write
      wr0("t3w", 9'h005, 32'h0000FFFF, 32'h0000FFFF);
      rd0("t3r", 9'h005, 32'hDEADFFFF);

      // requester 1 alone; moves the pointer back to 0
      @(negedge CK);
      set_req(1, 1'b1, 1'b1, 9'h006, 32'h12345678, 32'hFFFFFFFF);
      #1 check_eq("r1w_gnt", {30'd0, bus.gnt}, 32'h2);
      @(negedge CK);
      bus.req = '0;
      #1;
      check_eq("r1w_addr", {23'd0, mem_addr}, 32'h6);
      check_eq("r1w_din", mem_din, 32'h12345678);

      // T4 fairness, back-to-back reads
      for (int k = 0; k < 8; k++) begin
         @(negedge CK);
         if (k < 6) begin
            set_req(0, 1'b1, 1'b0, 9'h005, '0, '0);
            set_req(1, 1'b1, 1'b0, 9'h006, '0, '0);
         end else begin
            bus.req = '0;
         end
         #1;
         check_eq($sformatf("t4_gnt_%0d", k), {30'd0, bus.gnt}, {30'd0, exp_gnt[k]});
         check_eq($sformatf("t4_rv_%0d", k), {30'd0, bus.r_valid}, {30'd0, exp_rv[k]});
         if (k >= 2)
            check_eq($sformatf("t4_rdata_%0d", k), bus.r_rdata,
                     (exp_rv[k] == 2'b01) ? 32'hDEADFFFF : 32'h12345678);
      end

      // T5 trim changes only on idle
      @(negedge CK);
      set_req(0, 1'b1, 1'b0, 9'h005, '0, '0);
      #1 check_eq("t5_gnt", {30'd0, bus.gnt}, 32'h1);
      @(negedge CK);
      cfg_rddelay = 2'd3;
      cfg_wrdelay = 2'd2;
      #1 check_eq("t5_rd_a", {30'd0, mem_rddelay}, 32'd0);
      @(negedge CK);
      #1;
      check_eq("t5_rd_b", {30'd0, mem_rddelay}, 32'd0);
      check_eq("t5_csn_b", {31'd0, mem_csn}, 32'd0);
      @(negedge CK);
      bus.req = '0;
      #1 check_eq("t5_rd_c", {30'd0, mem_rddelay}, 32'd0);
      @(negedge CK);
      #1;
      check_eq("t5_rd_idle", {30'd0, mem_rddelay}, 32'd3);
      check_eq("t5_wr_idle", {30'd0, mem_wrdelay}, 32'd2);
      check_eq("t5_csn_idle", {31'd0, mem_csn}, 32'd1);

      // reset with a read in flight
      @(negedge CK);
      set_req(0, 1'b1, 1'b0, 9'h005, '0, '0);
      #1 check_eq("rst_gnt", {30'd0, bus.gnt}, 32'h1);
      @(negedge CK);
      RSTN    = 1'b0;
      bus.req = '1;
      #1;
      check_eq("rst_csn", {31'd0, mem_csn}, 32'd1);
      check_eq("rst_rv", {30'd0, bus.r_valid}, 32'd0);
      check_eq("rst_trim", {30'd0, mem_rddelay}, 32'd0);
      @(negedge CK);
      RSTN = 1'b1;
      wait_ready("rst", INIT_CYC);
      #1 check_eq("rst_rv_after", {30'd0, bus.r_valid}, 32'd0);
      @(negedge CK);
      set_req(0, 1'b1, 1'b0, 9'h005, '0, '0);
      set_req(1, 1'b1, 1'b0, 9'h006, '0, '0);
      #1 check_eq("rst_ptr", {30'd0, bus.gnt}, 32'h1);
      @(negedge CK);
      bus.req = '0;
      #1 check_eq("rst_rv_drop", {30'd0, bus.r_valid}, 32'd0);
      repeat (2) @(negedge CK);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish, got running expected done");
      $fatal(1);
   end

endmodule
